// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - merged reset request filter with staged domain release
// Tracks the cause of the last reset and keeps a saturating count of completed release sequences.
module rst_sequencer #(
  parameter int NUM_RST      = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 8,
  parameter int STAGE_GAP    = 4
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST_N,
  input  logic               BOARD_RST_SW,
  input  logic               SL_RST_N,
  output logic [NUM_RST-1:0] RST_N_OUT,
  output logic               RST_DONE,
  output logic [1:0]         RST_CAUSE,
  output logic [7:0]         RST_COUNT
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_CYC);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_RST - 1);
  localparam logic [NUM_RST-1:0] ONE_HOT0  = NUM_RST'(1);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sw_sync_q, sw_sync_d;
  logic [1:0]          sl_sync_q, sl_sync_d;
  logic [1:0]          fill_q, fill_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_RST-1:0]  rst_n_out_q, rst_n_out_d;
  logic                rst_done_q, rst_done_d;
  logic [1:0]          cause_q, cause_d;
  logic [7:0]          count_q, count_d;

  logic sw_req;
  logic sl_req;
  logic req;
  logic cause_en;

  always_comb begin
    sw_sync_d = {sw_sync_q[0], BOARD_RST_SW};
    sl_sync_d = {sl_sync_q[0], SL_RST_N};
    fill_d    = {fill_q[0], 1'b1};
    if (!sw_sync_q[1]) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_cnt_d = deb_cnt_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    // Gating with the live sample drops the request on the first low sample.
    sw_req   = sw_sync_q[1] && (deb_cnt_q == DEB_MAX);
    sl_req   = ~sl_sync_q[1];
    req      = sw_req | sl_req;
    // The synchronisers reset to "asserted"; that artefact must not mark a cause.
    cause_en = fill_q[1];
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    rst_n_out_d = rst_n_out_q;
    rst_done_d  = rst_done_q;
    cause_d     = cause_q;
    count_d     = count_q;

    case (state_q)
      S_HOLD: begin
        rst_n_out_d = '0;
        rst_done_d  = 1'b0;
        if (cause_en) begin
          cause_d = cause_q | {sl_req, sw_req};
        end
        if (req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RELEASE;
          hold_cnt_d = '0;
          idx_d      = '0;
          gap_d      = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (gap_q == GAP_LAST) begin
          rst_n_out_d = rst_n_out_q | (ONE_HOT0 << idx_q);
          gap_d       = '0;
          if (idx_q == IDX_LAST) begin
            state_d    = S_RUN;
            rst_done_d = 1'b1;
            if (count_q != 8'hFF) begin
              count_d = count_q + 8'd1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
      end
    endcase

    // A new request in RELEASE or RUN always wins and restarts from bit 0.
    if (req && (state_q != S_HOLD)) begin
      state_d     = S_HOLD;
      rst_n_out_d = '0;
      rst_done_d  = 1'b0;
      hold_cnt_d  = '0;
      idx_d       = '0;
      gap_d       = '0;
      cause_d     = {sl_req, sw_req};
      count_d     = count_q;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q     <= S_HOLD;
      sw_sync_q   <= '0;
      sl_sync_q   <= '0;
      fill_q      <= '0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      rst_n_out_q <= '0;
      rst_done_q  <= 1'b0;
      cause_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sw_sync_q   <= sw_sync_d;
      sl_sync_q   <= sl_sync_d;
      fill_q      <= fill_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      rst_n_out_q <= rst_n_out_d;
      rst_done_q  <= rst_done_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  assign RST_N_OUT = rst_n_out_q;
  assign RST_DONE  = rst_done_q;
  assign RST_CAUSE = cause_q;
  assign RST_COUNT = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scenario and random checks of rst_sequencer against a timing model
// The model derives outputs from the number of request-free edges since the last request.
module tb_rst_sequencer;

  localparam int NUM = 4;
  localparam int D   = 16;
  localparam int H   = 8;
  localparam int S   = 4;

  logic           SYS_CLK = 1'b0;
  logic           SYS_RST_N = 1'b0;
  logic           BOARD_RST_SW = 1'b0;
  logic           SL_RST_N = 1'b1;
  logic [NUM-1:0] RST_N_OUT;
  logic           RST_DONE;
  logic [1:0]     RST_CAUSE;
  logic [7:0]     RST_COUNT;

  int checks = 0;
  int errors = 0;

  int             edge_n;
  int             quiet;
  int             m_count;
  logic [1:0]     m_cause;
  logic [NUM-1:0] m_out;
  logic           m_done;
  bit             sl_hist[$];
  bit             sw_hist[$];

  rst_sequencer #(
    .NUM_RST(NUM), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .STAGE_GAP(S)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .SYS_RST_N(SYS_RST_N),
    .BOARD_RST_SW(BOARD_RST_SW),
    .SL_RST_N(SL_RST_N),
    .RST_N_OUT(RST_N_OUT),
    .RST_DONE(RST_DONE),
    .RST_CAUSE(RST_CAUSE),
    .RST_COUNT(RST_COUNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic model_reset();
    edge_n  = 0;
    quiet   = 0;
    m_count = 0;
    m_cause = 2'b00;
    m_out   = '0;
    m_done  = 1'b0;
    sl_hist.delete();
    sw_hist.delete();
    for (int i = 0; i < D + 4; i++) begin
      sl_hist.push_back(1'b0);
      sw_hist.push_back(1'b0);
    end
  endtask

  // One clock edge; the model sees inputs as they were at that edge.
  task automatic step();
    bit sl_req;
    bit sw_req;
    int n;
    @(posedge SYS_CLK);
    if (SYS_RST_N) begin
      edge_n++;
      sl_hist.push_back(SL_RST_N);
      sw_hist.push_back(BOARD_RST_SW);
      if (sl_hist.size() > D + 8) begin
        void'(sl_hist.pop_front());
        void'(sw_hist.pop_front());
      end
      sl_req = !sl_hist[sl_hist.size() - 3];
      sw_req = 1'b1;
      for (int k = 2; k <= D + 2; k++) begin
        if (!sw_hist[sw_hist.size() - 1 - k]) sw_req = 1'b0;
      end
      if (sl_req || sw_req) begin
        if (quiet >= H) m_cause = {sl_req, sw_req};
        else if (edge_n >= 3) m_cause = m_cause | {sl_req, sw_req};
        quiet = 0;
      end else begin
        if (quiet < H + NUM * S + 1) quiet++;
        if (quiet == H + NUM * S && m_count < 255) m_count++;
      end
    end
    n = (quiet < H) ? 0 : (((quiet - H) / S > NUM) ? NUM : (quiet - H) / S);
    m_out  = NUM'((1 << n) - 1);
    m_done = (n == NUM);
    #1;
  endtask

  task automatic test_reset();
    SYS_RST_N    = 1'b0;
    SL_RST_N     = 1'b1;
    BOARD_RST_SW = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (RST_N_OUT !== '0 || RST_DONE !== 1'b0 || RST_CAUSE !== 2'b00 || RST_COUNT !== 8'd0) begin
        errors++;
        $display("FAIL reset_values: got out=%b done=%b cause=%b count=%0d want all zero",
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT);
      end
    end
    SYS_RST_N = 1'b1;
  endtask

  task automatic test_power_on();
    logic [NUM-1:0] exp;
    for (int e = 1; e <= 40; e++) begin
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL power_on_model edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", e,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
      if (e >= 10 && e <= 26) begin
        exp = NUM'((1 << ((e - 10) / 4)) - 1);
        checks++;
        if (RST_N_OUT !== exp) begin
          errors++;
          $display("FAIL power_on_edge %0d: got out=%b want %b", e, RST_N_OUT, exp);
        end
      end
      if (e == 26) begin
        checks++;
        if (RST_DONE !== 1'b1 || RST_CAUSE !== 2'b00 || RST_COUNT !== 8'd1) begin
          errors++;
          $display("FAIL power_on_done: got done=%b cause=%b count=%0d want 1/00/1",
                   RST_DONE, RST_CAUSE, RST_COUNT);
        end
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 27; c++) begin
      BOARD_RST_SW = (c < 10 || (c >= 12 && c < 22)) ? 1'b1 : 1'b0;
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)} ||
          RST_N_OUT !== 4'hF) begin
        errors++;
        $display("FAIL bounce_ignored cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
    end
    BOARD_RST_SW = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 31) BOARD_RST_SW = 1'b0;
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL sw_hold_model edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
      if (c == 18 || c == 19) begin
        checks++;
        if (RST_N_OUT !== ((c == 18) ? 4'hF : 4'h0)) begin
          errors++;
          $display("FAIL sw_hold_edge %0d: got out=%b want %b", c, RST_N_OUT, (c == 18) ? 4'hF : 4'h0);
        end
      end
    end
    checks++;
    if (RST_CAUSE !== 2'b01 || RST_DONE !== 1'b1 || RST_COUNT !== 8'd2) begin
      errors++;
      $display("FAIL sw_restart: got cause=%b done=%b count=%0d want 01/1/2", RST_CAUSE, RST_DONE, RST_COUNT);
    end
  endtask

  task automatic test_sl_run();
    SL_RST_N = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 6) SL_RST_N = 1'b1;
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL sl_run_model edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
      if (c == 2 || c == 3 || c == 5 + 13 || c == 5 + 14) begin
        checks++;
        if (RST_N_OUT !== ((c == 2) ? 4'hF : (c == 19) ? 4'b0001 : 4'h0)) begin
          errors++;
          $display("FAIL sl_run_edge %0d: got out=%b", c, RST_N_OUT);
        end
      end
    end
    checks++;
    if (RST_CAUSE !== 2'b10 || RST_DONE !== 1'b1 || RST_COUNT !== 8'd3) begin
      errors++;
      $display("FAIL sl_run_final: got cause=%b done=%b count=%0d want 10/1/3", RST_CAUSE, RST_DONE, RST_COUNT);
    end
  endtask

  task automatic test_sl_release_abort();
    SL_RST_N = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 2) SL_RST_N = 1'b1;
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL abort_model cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
      if (c > 3 && m_out == 4'b0011) break;
    end
    checks++;
    if (RST_N_OUT !== 4'b0011) begin
      errors++;
      $display("FAIL abort_setup: got out=%b want 0011", RST_N_OUT);
    end
    SL_RST_N = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (RST_N_OUT !== ((c == 3) ? 4'b0000 : 4'b0011) || RST_COUNT !== 8'd3) begin
        errors++;
        $display("FAIL abort_edge %0d: got out=%b count=%0d", c, RST_N_OUT, RST_COUNT);
      end
    end
    SL_RST_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL abort_restart cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
    end
    checks++;
    if (RST_DONE !== 1'b1 || RST_COUNT !== 8'd4) begin
      errors++;
      $display("FAIL abort_final: got done=%b count=%0d want 1/4", RST_DONE, RST_COUNT);
    end
  endtask

  task automatic test_both_sources();
    SL_RST_N     = 1'b0;
    BOARD_RST_SW = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c == 25) BOARD_RST_SW = 1'b0;
      if (c == 30) BOARD_RST_SW = 1'b1;
      if (c == 55) begin
        BOARD_RST_SW = 1'b0;
        SL_RST_N     = 1'b1;
      end
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL both_model cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
      if (c == 24 || c == 54 || c == 99) begin
        checks++;
        if (RST_CAUSE !== 2'b11) begin
          errors++;
          $display("FAIL both_cause cyc %0d: got cause=%b want 11", c, RST_CAUSE);
        end
      end
    end
    checks++;
    if (RST_DONE !== 1'b1 || RST_COUNT !== 8'd5) begin
      errors++;
      $display("FAIL both_final: got done=%b count=%0d want 1/5", RST_DONE, RST_COUNT);
    end
  endtask

  task automatic test_random();
    int kind;
    int len;
    for (int ep = 0; ep < 60; ep++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       len = int'($urandom_range(1, 6));
        1:       len = int'($urandom_range(5, 30));
        2:       len = int'($urandom_range(3, 12));
        default: len = int'($urandom_range(5, 45));
      endcase
      for (int c = 0; c < len; c++) begin
        if (kind == 0) SL_RST_N = 1'b0;
        if (kind == 1) BOARD_RST_SW = 1'b1;
        if (kind == 2) begin
          BOARD_RST_SW = 1'($urandom_range(0, 1));
          SL_RST_N     = 1'($urandom_range(0, 1));
        end
        step();
        checks++;
        if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
          errors++;
          if (errors <= 30)
            $display("FAIL random ep %0d cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", ep, c,
                     RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
        end
      end
      SL_RST_N     = 1'b1;
      BOARD_RST_SW = 1'b0;
    end
  endtask

  task automatic test_saturate_and_async();
    int len;
    for (int sq = 0; sq < 300; sq++) begin
      len = int'($urandom_range(1, 4));
      SL_RST_N = 1'b0;
      for (int c = 0; c < 70; c++) begin
        if (c == len) SL_RST_N = 1'b1;
        step();
        checks++;
        if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
          errors++;
          if (errors <= 30)
            $display("FAIL saturate seq %0d cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", sq, c,
                     RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
        end
        if (c > len + 3 && m_done) break;
      end
    end
    checks++;
    if (RST_COUNT !== 8'd255) begin
      errors++;
      $display("FAIL count_saturate: got count=%0d want 255", RST_COUNT);
    end
    SL_RST_N = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 2) SL_RST_N = 1'b1;
      step();
      if (c > 3 && m_out == 4'b0011) break;
    end
    #2;
    SYS_RST_N = 1'b0;
    #1;
    checks++;
    if (RST_N_OUT !== 4'b0000 || RST_DONE !== 1'b0 || RST_COUNT !== 8'd0 || RST_CAUSE !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got out=%b done=%b cause=%b count=%0d want 0000/0/00/0",
               RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT);
    end
    model_reset();
    step();
    step();
    SYS_RST_N = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      checks++;
      if ({RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT} !== {m_out, m_done, m_cause, 8'(m_count)}) begin
        errors++;
        $display("FAIL after_async edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 RST_N_OUT, RST_DONE, RST_CAUSE, RST_COUNT, m_out, m_done, m_cause, m_count);
      end
    end
    checks++;
    if (RST_N_OUT !== 4'hF || RST_COUNT !== 8'd1 || RST_CAUSE !== 2'b00) begin
      errors++;
      $display("FAIL after_async_final: got out=%b count=%0d cause=%b want 1111/1/00",
               RST_N_OUT, RST_COUNT, RST_CAUSE);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_bounce();
    test_sl_run();
    test_sl_release_abort();
    test_both_sources();
    test_random();
    test_saturate_and_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
